// File: rtl/spi_controller.sv
// spi_controller -- sequencing FSM for a simple SPI peripheral.
// One transaction is an address phase (7 address bits + R/W bit) followed by
// a WIDTH-bit data phase that is either shifted out (read) or captured (write).
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   reset          synchronous active-high reset
//   sclkEdge       one-clk pulse, the shift register shifts this cycle
//   csConditioned  conditioned chip select, active low
//   rwBit          R/W bit from the shift register (1 = read)
//   srWe           shift register parallel-load strobe
//   addrWe         address latch write enable
//   dmWe           data memory write enable
//   misoBufe       MISO tri-state buffer enable
//   state          current state encoding
//   bitCount       sclkEdge pulses counted in the current phase
module spi_controller #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclkEdge,
  input  logic       csConditioned,
  input  logic       rwBit,
  output logic       srWe,
  output logic       addrWe,
  output logic       dmWe,
  output logic       misoBufe,
  output logic [3:0] state,
  output logic [3:0] bitCount
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    GET         = 4'd1,
    GOT         = 4'd2,
    READ_WAIT   = 4'd3,
    READ_LOAD   = 4'd4,
    READ_SHIFT  = 4'd5,
    WRITE_GET   = 4'd6,
    WRITE_STORE = 4'd7,
    DONE        = 4'd8
  } state_t;

  // Count value at which the next pulse is the WIDTH-th of the phase.
  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t     cur, nxt;
  logic [3:0] cnt, cntNxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE;
      cnt <= 4'd0;
    end else begin
      cur <= nxt;
      cnt <= cntNxt;
    end
  end

  always_comb begin
    nxt    = cur;
    cntNxt = cnt;
    if (cur != IDLE && csConditioned) begin
      // Deselect aborts whatever is in progress.
      nxt    = IDLE;
      cntNxt = 4'd0;
    end else begin
      case (cur)
        IDLE: begin
          if (!csConditioned) begin
            nxt    = GET;
            cntNxt = 4'd0;
          end
        end
        GET, READ_SHIFT, WRITE_GET: begin
          if (sclkEdge) begin
            if (cnt == LAST) begin
              // Phase complete: counter clears as the phase ends, so it
              // never shows WIDTH and reads 0 in the following state.
              cntNxt = 4'd0;
              case (cur)
                GET:        nxt = GOT;
                READ_SHIFT: nxt = DONE;
                default:    nxt = WRITE_STORE;
              endcase
            end else begin
              cntNxt = cnt + 4'd1;
            end
          end
        end
        GOT: begin
          cntNxt = 4'd0;
          nxt    = rwBit ? READ_WAIT : WRITE_GET;
        end
        READ_WAIT:   nxt = READ_LOAD;  // one cycle of memory read latency
        READ_LOAD: begin
          nxt    = READ_SHIFT;
          cntNxt = 4'd0;
        end
        WRITE_STORE: nxt = DONE;
        DONE:        nxt = DONE;       // wait for deselect, edges ignored
        default: begin
          nxt    = IDLE;
          cntNxt = 4'd0;
        end
      endcase
    end
  end

  // Moore outputs: decoded from the state register only.
  assign addrWe   = (cur == GOT);
  assign srWe     = (cur == READ_LOAD);
  assign misoBufe = (cur == READ_SHIFT);
  assign dmWe     = (cur == WRITE_STORE);
  assign state    = cur;
  assign bitCount = cnt;

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;

  localparam int W = 8;
  localparam int L = 60;  // cycles per random transaction window
  localparam int NONE = 1000;

  logic       clk = 1'b0;
  logic       reset, sclkEdge, csConditioned, rwBit;
  logic       srWe, addrWe, dmWe, misoBufe;
  logic [3:0] state, bitCount;

  int checks = 0;
  int failures = 0;

  spi_controller #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sclkEdge(sclkEdge), .csConditioned(csConditioned),
    .rwBit(rwBit), .srWe(srWe), .addrWe(addrWe), .dmWe(dmWe), .misoBufe(misoBufe),
    .state(state), .bitCount(bitCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, cs, sc, rw;
    int   st, bc;
  } vec_t;

  vec_t vecs[$];

  // Enables implied by a state: {srWe, addrWe, dmWe, misoBufe}.
  function automatic logic [3:0] enOf(int st);
    return {st == 4, st == 2, st == 7, st == 5};
  endfunction

  function automatic void addV(logic rst, logic cs, logic sc, logic rw, int st, int bc);
    vec_t v;
    v.rst = rst; v.cs = cs; v.sc = sc; v.rw = rw; v.st = st; v.bc = bc;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, int st, int bc);
    logic [3:0] en, expEn;
    en = {srWe, addrWe, dmWe, misoBufe};
    expEn = enOf(st);
    checks++;
    if (int'(state) != st || int'(bitCount) != bc || en !== expEn) begin
      failures++;
      $display("FAIL %s[%0d]: state=%0d bitCount=%0d en=%b, expected state=%0d bitCount=%0d en=%b",
               name, idx, state, bitCount, en, st, bc, expEn);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rst, logic cs, logic sc, logic rw);
    reset = rst; csConditioned = cs; sclkEdge = sc; rwBit = rw;
  endtask

  // ---------------- random transaction reference model ----------------
  logic scArr[L];
  int   xCs;   // first cycle with cs high
  bit   rwT;

  // Cycle of the n-th pulse at or after 'lo' that precedes deselect.
  function automatic int nth(int lo, int n);
    int k = 0;
    for (int t = lo; t < xCs && t < L; t++)
      if (scArr[t]) begin
        k++;
        if (k == n) return t;
      end
    return NONE;
  endfunction

  function automatic int countP(int lo, int hi);
    int k = 0;
    for (int t = lo; t <= hi && t < xCs && t < L; t++)
      if (scArr[t]) k++;
    return k;
  endfunction

  // Expected state/bitCount during cycle s; cs fell in cycle 0 so GET starts in cycle 1.
  task automatic model(int s, output int st, output int bc);
    int a, d;
    st = 0; bc = 0;
    if (s > xCs) return;
    a = nth(1, W);
    if (a == NONE || s <= a) begin st = 1; bc = countP(1, s - 1); return; end
    if (s == a + 1) begin st = 2; return; end
    if (rwT) begin
      if (s == a + 2) begin st = 3; return; end
      if (s == a + 3) begin st = 4; return; end
      d = nth(a + 4, W);
      if (s <= d) begin st = 5; bc = countP(a + 4, s - 1); end
      else st = 8;
    end else begin
      d = nth(a + 2, W);
      if (s <= d) begin st = 6; bc = countP(a + 2, s - 1); end
      else if (s == d + 1) st = 7;
      else st = 8;
    end
  endtask

  initial begin
    int st, bc;
    drive(1, 1, 0, 0);

    // ---------------- directed vector table ----------------
    // Reset with cs low and edges pulsing, then idle with cs high.
    addV(1, 0, 1, 0, 0, 0);
    addV(1, 0, 1, 0, 0, 0);
    addV(0, 1, 1, 0, 0, 0);
    // Read: address phase, edges ignored in GOT/READ_WAIT/READ_LOAD, reset mid-shift.
    addV(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < W; i++) addV(0, 0, 1, 1, (i < W-1) ? 1 : 2, (i < W-1) ? i+1 : 0);
    addV(0, 0, 1, 1, 3, 0);
    addV(0, 0, 1, 1, 4, 0);
    addV(0, 0, 1, 1, 5, 0);
    for (int i = 0; i < 3; i++) addV(0, 0, 1, 1, 5, i+1);
    addV(1, 0, 1, 1, 0, 0);
    // Full write, edges in DONE ignored, then deselect.
    addV(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < W; i++) addV(0, 0, 1, 0, (i < W-1) ? 1 : 2, (i < W-1) ? i+1 : 0);
    addV(0, 0, 0, 0, 6, 0);
    for (int i = 0; i < W; i++) addV(0, 0, 1, 0, (i < W-1) ? 6 : 7, (i < W-1) ? i+1 : 0);
    addV(0, 0, 1, 0, 8, 0);
    addV(0, 0, 1, 0, 8, 0);
    addV(0, 0, 1, 0, 8, 0);
    addV(0, 1, 0, 0, 0, 0);
    addV(0, 1, 0, 0, 0, 0);
    // Full read to DONE.
    addV(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < W; i++) addV(0, 0, 1, 1, (i < W-1) ? 1 : 2, (i < W-1) ? i+1 : 0);
    addV(0, 0, 0, 1, 3, 0);
    addV(0, 0, 0, 1, 4, 0);
    addV(0, 0, 0, 1, 5, 0);
    for (int i = 0; i < W; i++) addV(0, 0, 1, 1, (i < W-1) ? 5 : 8, (i < W-1) ? i+1 : 0);
    addV(0, 0, 1, 1, 8, 0);
    addV(0, 1, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].cs, vecs[i].sc, vecs[i].rw);
      step();
      check("vec", i, vecs[i].st, vecs[i].bc);
    end

    // ---------------- abort in WRITE_GET after 5 pulses ----------------
    drive(0, 0, 0, 0);
    step(); check("abort", 0, 1, 0);
    for (int i = 0; i < W; i++) begin
      drive(0, 0, 1, 0);
      step(); check("abortAddr", i, (i < W-1) ? 1 : 2, (i < W-1) ? i+1 : 0);
    end
    drive(0, 0, 0, 0);
    step(); check("abort", 1, 6, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      step(); check("abortData", i, 6, i+1);
    end
    drive(0, 1, 1, 0);
    step(); check("abort", 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0);
      step(); check("abortIdle", i, 0, 0);
    end

    // ---------------- randomized transactions vs model ----------------
    for (int n = 0; n < 40; n++) begin
      rwT = 1'($urandom_range(0, 1));
      xCs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, L-2)) : L-3;
      for (int t = 0; t < L; t++) scArr[t] = ($urandom_range(0, 9) < 6);
      for (int t = 0; t < L; t++) begin
        drive(0, (t >= xCs), scArr[t], rwT);
        step();
        model(t + 1, st, bc);
        check("rand", n * L + t, st, bc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
